adxl362_spi_os: RTL and testbench

Oversampled, parametrised SPI slave front end for the ADXL362 behavioural model. Synchronises SCLK/MOSI/nCS into the clk_16mhz domain and decodes the ADXL362 command set: register write 0x0A, register read 0x0B, FIFO read 0x0D. Supports burst transfers with address auto-increment and all four SPI modes. Drives the model's register file and FIFO through single-cycle strobes.

---
 rtl/adxl362_spi_os_if.sv | 8 +
 rtl/adxl362_spi_os.sv | 111 +++++++++++
 tb/tb_adxl362_spi_os.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adxl362_spi_os_if.sv
// adxl362_spi_os_if: register-file and FIFO strobe bus between the SPI front end and the model
interface adxl362_spi_os_if #(parameter int ADDR_WIDTH = 6);
  logic [ADDR_WIDTH-1:0] address;
  logic [7:0] data_write, data_read, data_fifo_read;
  logic write, read, fifo_pop;
  modport master(output address, data_write, write, read, fifo_pop, input data_read, data_fifo_read);
  modport slave(input address, data_write, write, read, fifo_pop, output data_read, data_fifo_read);
endinterface

// File: rtl/adxl362_spi_os.sv
// adxl362_spi_os: oversampled SPI slave decoding the ADXL362 write/read/FIFO command set
module adxl362_spi_os #(
  parameter int ADDR_WIDTH = 6,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_16mhz,
  input  logic rst,
  input  logic SCLK,
  input  logic MOSI,
  input  logic nCS,
  output logic MISO,
  output logic busy,
  output logic cmd_error,
  adxl362_spi_os_if.master bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, FIFO_DATA, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, ncs_sr;
  logic sclk_q, ncs_q, wr_mode, rd_pend, read_q, pop_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] tx, rx_n;
  logic sclk_s, ncs_s, sample, shift_e, ncs_fall, ncs_rise, done, bad;
  assign MISO = tx[7] & ~nCS;
  assign busy = state != IDLE;
  always_comb begin
    sclk_s = sclk_sr[SYNC_STAGES-1];
    ncs_s = ncs_sr[SYNC_STAGES-1];
    sample = (CPOL ^ CPHA) ? (~sclk_s & sclk_q) : (sclk_s & ~sclk_q);
    shift_e = (CPOL ^ CPHA) ? (sclk_s & ~sclk_q) : (~sclk_s & sclk_q);
    ncs_fall = ncs_q & ~ncs_s;
    ncs_rise = ~ncs_q & ncs_s;
    rx_n = {rx, mosi_sr[SYNC_STAGES-1]};
    done = sample && bit_cnt == 3'd7 && state != IDLE && !ncs_rise;
    bad = rx_n != 8'h0A && rx_n != 8'h0B && rx_n != 8'h0D;
    state_n = state;
    if (ncs_rise) state_n = IDLE;
    else case (state)
      IDLE: state_n = ncs_fall ? CMD : IDLE;
      CMD: state_n = !done ? CMD : bad ? IGNORE : rx_n == 8'h0D ? FIFO_DATA : ADDR;
      ADDR: state_n = !done ? ADDR : wr_mode ? WR_DATA : RD_DATA;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk_16mhz or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_16mhz or negedge rst) begin
    if (!rst) begin
      {sclk_sr, mosi_sr, ncs_sr} <= '0;
      {sclk_q, ncs_q, wr_mode, rd_pend, read_q, pop_q, cmd_error} <= '0;
      {bus.write, bus.read, bus.fifo_pop} <= '0;
      bus.address <= '0;
      bus.data_write <= '0;
      bit_cnt <= '0;
      rx <= '0;
      tx <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], SCLK};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
      ncs_sr <= {ncs_sr[SYNC_STAGES-2:0], nCS};
      sclk_q <= sclk_s;
      ncs_q <= ncs_s;
      read_q <= bus.read;
      pop_q <= bus.fifo_pop;
      bus.write <= 1'b0;
      bus.read <= rd_pend;
      bus.fifo_pop <= 1'b0;
      cmd_error <= 1'b0;
      rd_pend <= 1'b0;
      if (bus.write) bus.address <= bus.address + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
        rx <= '0;
        tx <= '0;
      end else begin
        if (sample) begin
          rx <= rx_n[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        // the edge at a byte boundary never shifts, so tx[7] of a fresh byte is presented first
        if (read_q) tx <= bus.data_read;
        else if (pop_q) tx <= bus.data_fifo_read;
        else if (shift_e && bit_cnt != 3'd0) tx <= {tx[6:0], 1'b0};
      end
      if (done) case (state)
        CMD: begin
          wr_mode <= rx_n == 8'h0A;
          cmd_error <= bad;
          bus.fifo_pop <= rx_n == 8'h0D;
        end
        ADDR: begin
          bus.address <= rx_n[ADDR_WIDTH-1:0];
          bus.read <= !wr_mode;
        end
        WR_DATA: begin
          bus.data_write <= rx_n;
          bus.write <= 1'b1;
        end
        RD_DATA: begin
          bus.address <= bus.address + 1'b1;
          rd_pend <= 1'b1;
        end
        FIFO_DATA: bus.fifo_pop <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adxl362_spi_os.sv
// tb_adxl362_spi_os: directed mode-0 and mode-3 transactions against scoreboarded register/FIFO models
`timescale 1ns/1ps
module tb_adxl362_spi_os;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mosi = 1'b0, sclk0 = 1'b0, ncs0 = 1'b1, sclk3 = 1'b1, ncs3 = 1'b1;
  logic miso0, miso3, busy0, busy3, err0, err3;
  int n_chk = 0, n_pass = 0;
  int nwr0 = 0, nrd0 = 0, npop0 = 0, nerr0 = 0, nstb3 = 0, ovl = 0;
  logic [13:0] wr_q[$];
  logic [5:0] rd_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] fifo_q[$];
  always #5 clk = ~clk;
  adxl362_spi_os_if #(.ADDR_WIDTH(6)) bus0 ();
  adxl362_spi_os_if #(.ADDR_WIDTH(6)) bus3 ();
  adxl362_spi_os #(.ADDR_WIDTH(6), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk_16mhz(clk), .rst(rst), .SCLK(sclk0), .MOSI(mosi), .nCS(ncs0), .MISO(miso0),
    .busy(busy0), .cmd_error(err0), .bus(bus0));
  adxl362_spi_os #(.ADDR_WIDTH(6), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut3 (
    .clk_16mhz(clk), .rst(rst), .SCLK(sclk3), .MOSI(mosi), .nCS(ncs3), .MISO(miso3),
    .busy(busy3), .cmd_error(err3), .bus(bus3));
  // register file returns address^0xA5 the cycle after read; FIFO returns 0 once drained
  always @(posedge clk) if (bus0.read) bus0.data_read <= {2'b00, bus0.address} ^ 8'hA5;
  always @(posedge clk) if (bus3.read) bus3.data_read <= {2'b00, bus3.address} ^ 8'hA5;
  always @(posedge clk) if (bus0.fifo_pop) bus0.data_fifo_read <= fifo_q.size() != 0 ? fifo_q.pop_front() : 8'h00;
  assign bus3.data_fifo_read = 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(negedge clk) begin
    nwr0 += int'(bus0.write);
    nrd0 += int'(bus0.read);
    npop0 += int'(bus0.fifo_pop);
    nerr0 += int'(err0);
    nstb3 += int'(bus3.write) + int'(bus3.read) + int'(bus3.fifo_pop) + int'(err3);
    if (int'(bus0.write) + int'(bus0.read) + int'(bus0.fifo_pop) > 1) ovl++;
    if (bus0.write) begin
      chk("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) chk("wr_addr_data", {bus0.address, bus0.data_write}, wr_q.pop_front());
    end
    if (bus0.read) begin
      chk("rd_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) chk("rd_addr", bus0.address, rd_q.pop_front());
    end
  end
  task automatic wait_c(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xfer(input bit m3, input logic [7:0] d, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      if (!m3) begin
        mosi = d[i]; wait_c(H); r[i] = miso0; sclk0 = 1'b1; wait_c(H); sclk0 = 1'b0;
      end else begin
        sclk3 = 1'b0; mosi = d[i]; wait_c(H); r[i] = miso3; sclk3 = 1'b1; wait_c(H);
      end
    end
  endtask
  task automatic cs(input bit m3, input logic v);
    wait_c(H);
    if (m3) ncs3 = v; else ncs0 = v;
    wait_c(H);
  endtask
  task automatic rx_byte(input bit m3, input logic [7:0] d, input string tag);
    logic [7:0] r;
    xfer(m3, d, 8, r);
    chk(tag, r, miso_q.pop_front());
  endtask
  task automatic chk_reset(input string tag, input bit m3);
    if (m3) chk(tag, {bus3.address, bus3.data_write, bus3.write, bus3.read, bus3.fifo_pop, err3, busy3, miso3}, 0);
    else chk(tag, {bus0.address, bus0.data_write, bus0.write, bus0.read, bus0.fifo_pop, err0, busy0, miso0}, 0);
  endtask
  initial begin
    logic [7:0] r, r2;
    int w, rd, p, e;
    wait_c(4);
    chk_reset("reset0", 0);
    chk_reset("reset3", 1);
    rst = 1'b1;
    wait_c(4);
    // mode 0 single write
    w = nwr0; rd = nrd0; p = npop0;
    wr_q.push_back({6'h20, 8'h5A});
    cs(0, 0); xfer(0, 8'h0A, 8, r); xfer(0, 8'h20, 8, r); xfer(0, 8'h5A, 8, r); cs(0, 1);
    chk("wr_count", nwr0 - w, 1);
    chk("wr_no_rd_pop", (nrd0 - rd) + (npop0 - p), 0);
    chk("wr_addr_inc", bus0.address, 6'h21);
    // burst read wrapping past 0x3F
    rd_q = '{6'h3F, 6'h00, 6'h01, 6'h02};
    cs(0, 0); xfer(0, 8'h0B, 8, r); xfer(0, 8'h3F, 8, r2);
    chk("cmd_addr_miso_zero", {r, r2}, 0);
    miso_q = '{8'h9A, 8'hA5, 8'hA4};
    rx_byte(0, 8'h00, "rd_b0"); rx_byte(0, 8'h00, "rd_b1"); rx_byte(0, 8'h00, "rd_b2");
    cs(0, 1);
    chk("rd_all_issued", rd_q.size(), 0);
    chk("rd_final_addr", bus0.address, 6'h02);
    // FIFO read
    p = npop0; rd = nrd0;
    fifo_q = '{8'h11, 8'h22};
    cs(0, 0); xfer(0, 8'h0D, 8, r);
    miso_q = '{8'h11, 8'h22};
    rx_byte(0, 8'h00, "fifo_b0"); rx_byte(0, 8'h00, "fifo_b1");
    cs(0, 1);
    chk("fifo_pops", npop0 - p, 3);
    chk("fifo_no_read", nrd0 - rd, 0);
    chk("fifo_addr_kept", bus0.address, 6'h02);
    // unrecognised command, then a normal write
    w = nwr0; rd = nrd0; p = npop0; e = nerr0;
    cs(0, 0); xfer(0, 8'h0C, 8, r);
    miso_q = '{8'h00, 8'h00};
    rx_byte(0, 8'hFF, "ign_b0"); rx_byte(0, 8'hFF, "ign_b1");
    chk("ign_busy", busy0, 1);
    cs(0, 1);
    chk("cmd_error_count", nerr0 - e, 1);
    chk("ign_no_strobes", (nwr0 - w) + (nrd0 - rd) + (npop0 - p), 0);
    wr_q.push_back({6'h05, 8'h77});
    cs(0, 0); xfer(0, 8'h0A, 8, r); xfer(0, 8'h05, 8, r); xfer(0, 8'h77, 8, r); cs(0, 1);
    chk("after_err_wr_count", nwr0 - w, 1);
    // abort mid data byte
    w = nwr0;
    cs(0, 0); xfer(0, 8'h0A, 8, r); xfer(0, 8'h10, 8, r); xfer(0, 8'hC3, 4, r);
    chk("abort_busy_before", busy0, 1);
    ncs0 = 1'b1;
    wait_c(4);
    chk("abort_busy_dropped", busy0, 0);
    wait_c(H);
    chk("abort_no_write", nwr0 - w, 0);
    chk("abort_addr", bus0.address, 6'h10);
    // mode 3 read interrupted by reset
    cs(1, 0); xfer(1, 8'h0B, 8, r); xfer(1, 8'h12, 8, r);
    miso_q = '{8'hB7, 8'hB6};
    rx_byte(1, 8'h00, "m3_b0"); rx_byte(1, 8'h00, "m3_b1");
    xfer(1, 8'h00, 4, r);
    rst = 1'b0;
    wait_c(2);
    chk_reset("midread_reset3", 1);
    rst = 1'b1;
    e = nstb3;
    xfer(1, 8'h00, 4, r);
    chk("no_resume_busy", busy3, 0);
    chk("no_resume_miso", r, 0);
    chk("no_resume_strobes", nstb3 - e, 0);
    cs(1, 1);
    cs(1, 0); xfer(1, 8'h0B, 8, r); xfer(1, 8'h3E, 8, r);
    miso_q = '{8'h9B, 8'h9A};
    rx_byte(1, 8'h00, "m3_post_b0"); rx_byte(1, 8'h00, "m3_post_b1");
    cs(1, 1);
    chk("strobe_overlap", ovl, 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
